// File: rtl/mem_arbiter.sv
// Arbiter and sequencer sharing one data-memory port between instruction fetch and load/store.
// Data wins by default; a saturating starvation counter forces a fetch grant after STARVE_MAX.
module mem_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
  localparam logic [3:0] LastWait  = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StRwait, StResp} state_e;

  state_e     state_q;
  logic       owner_d_q;  // 1: the transaction in flight belongs to the data port
  logic [3:0] wait_q;
  logic [3:0] starve_q;

  logic arb_point;
  logic pick_if;
  logic pick_d;

  // A store frees the port at the end of its ISSUE cycle, so it is also an arbitration point.
  always_comb begin
    arb_point = (state_q == StIdle) || (state_q == StResp) ||
                ((state_q == StIssue) && mem_write_en);
    pick_if   = if_req && (!d_req || (starve_q == StarveMax));
    pick_d    = d_req && !pick_if;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      owner_d_q      <= 1'b0;
      wait_q         <= 4'd0;
      starve_q       <= 4'd0;
      if_gnt         <= 1'b0;
      d_gnt          <= 1'b0;
      if_rvalid      <= 1'b0;
      d_rvalid       <= 1'b0;
      if_rdata       <= 32'd0;
      d_rdata        <= 32'd0;
      mem_write_en   <= 1'b0;
      mem_addr       <= 32'd0;
      mem_write_data <= 32'd0;
      busy           <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (arb_point) begin
        mem_write_en <= 1'b0;
        if (pick_if || pick_d) begin
          state_q      <= StIssue;
          busy         <= 1'b1;
          owner_d_q    <= pick_d;
          if_gnt       <= pick_if;
          d_gnt        <= pick_d;
          mem_addr     <= pick_d ? d_addr : if_addr;
          mem_write_en <= pick_d & d_we;
          if (pick_d) begin
            mem_write_data <= d_wdata;
          end
          if (pick_if || !if_req) begin
            starve_q <= 4'd0;
          end else if (starve_q < StarveMax) begin
            starve_q <= starve_q + 4'd1;
          end
        end else begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      end else begin
        unique case (state_q)
          StIssue: begin
            state_q <= StRwait;
            wait_q  <= LastWait;
          end
          StRwait: begin
            if (wait_q == 4'd0) begin
              state_q <= StResp;
              if (owner_d_q) begin
                d_rdata  <= mem_read_data;
                d_rvalid <= 1'b1;
              end else begin
                if_rdata  <= mem_read_data;
                if_rvalid <= 1'b1;
              end
            end else begin
              wait_q <= wait_q - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: dut_a (MEM_LAT=1, STARVE_MAX=2) and dut_b (MEM_LAT=3, STARVE_MAX=4)
// share stimulus; each scenario checks one instance against hand-computed values.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] mem_read_data;

  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_write_en, a_busy;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_write_data;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_write_en, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_write_data;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) dut_a (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid),
    .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(a_d_gnt),
    .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_write_en(a_mem_write_en), .mem_addr(a_mem_addr), .mem_write_data(a_mem_write_data),
    .mem_read_data(mem_read_data), .busy(a_busy)
  );

  mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
    .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(b_d_gnt),
    .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_write_en(b_mem_write_en), .mem_addr(b_mem_addr), .mem_write_data(b_mem_write_data),
    .mem_read_data(mem_read_data), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          ngr;
    int          dbl;
    int          nrv;
    int          lat;
    logic [5:0]  seq;

    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_read_data = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_gnts", {28'd0, a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid}, 32'd0);
    check("rst_we", 32'(a_mem_write_en), 32'd0);
    check("rst_addr", a_mem_addr, 32'd0);
    check("rst_wdata", a_mem_write_data, 32'd0);
    check("rst_rdata", a_if_rdata | a_d_rdata, 32'd0);

    // Fetch, MEM_LAT=1
    if_req = 1'b1; if_addr = 32'h10; mem_read_data = 32'hDEADBEEF;
    tick();                                    // T1
    check("f_t1_if_gnt", 32'(a_if_gnt), 32'd1);
    check("f_t1_d_gnt", 32'(a_d_gnt), 32'd0);
    check("f_t1_addr", a_mem_addr, 32'h10);
    check("f_t1_busy", 32'(a_busy), 32'd1);
    if_req = 1'b0;
    tick();                                    // T2 RWAIT
    check("f_t2_addr", a_mem_addr, 32'h10);
    check("f_t2_gnt_we", {30'd0, a_if_gnt, a_mem_write_en}, 32'd0);
    check("f_t2_rvalid", 32'(a_if_rvalid), 32'd0);
    tick();                                    // T3 RESP
    check("f_t3_rvalid", 32'(a_if_rvalid), 32'd1);
    check("f_t3_rdata", a_if_rdata, 32'hDEADBEEF);
    check("f_t3_d_silent", {31'd0, a_d_rvalid}, 32'd0);
    tick();                                    // T4 IDLE
    check("f_t4_idle", {30'd0, a_busy, a_if_rvalid}, 32'd0);

    // Back-to-back stores
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    tick();                                    // T1
    check("s1_gnt_we", {30'd0, a_d_gnt, a_mem_write_en}, 32'd3);
    check("s1_addr", a_mem_addr, 32'h40);
    check("s1_wdata", a_mem_write_data, 32'h12345678);
    check("s1_rvalid", 32'(a_d_rvalid), 32'd0);
    d_addr = 32'h44; d_wdata = 32'hA5A5A5A5;
    tick();                                    // T2
    check("s2_gnt_we", {30'd0, a_d_gnt, a_mem_write_en}, 32'd3);
    check("s2_addr", a_mem_addr, 32'h44);
    check("s2_wdata", a_mem_write_data, 32'hA5A5A5A5);
    check("s2_rvalid", 32'(a_d_rvalid), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick();                                    // T3
    check("s3_quiet", {29'd0, a_mem_write_en, a_d_gnt, a_busy}, 32'd0);
    check("s3_rvalid", 32'(a_d_rvalid), 32'd0);

    // Simultaneous load 0x80 vs fetch 0x04
    if_req = 1'b1; if_addr = 32'h04; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    mem_read_data = 32'h11112222;
    tick();                                    // T1
    check("sim_t1_gnts", {30'd0, a_if_gnt, a_d_gnt}, 32'd1);
    check("sim_t1_addr", a_mem_addr, 32'h80);
    d_req = 1'b0;
    tick();                                    // T2 RWAIT
    check("sim_t2_gnts", {30'd0, a_if_gnt, a_d_gnt}, 32'd0);
    tick();                                    // T3 RESP
    check("sim_t3_d_rvalid", 32'(a_d_rvalid), 32'd1);
    check("sim_t3_d_rdata", a_d_rdata, 32'h11112222);
    check("sim_t3_if_gnt", 32'(a_if_gnt), 32'd0);
    mem_read_data = 32'h33334444;
    tick();                                    // T4 fetch issue
    check("sim_t4_if_gnt", {30'd0, a_if_gnt, a_d_gnt}, 32'd2);
    check("sim_t4_addr", a_mem_addr, 32'h04);
    if_req = 1'b0;
    tick(); tick();                            // T6 RESP
    check("sim_t6_if_rvalid", 32'(a_if_rvalid), 32'd1);
    check("sim_t6_if_rdata", a_if_rdata, 32'h33334444);
    check("sim_t6_d_rdata_held", a_d_rdata, 32'h11112222);
    tick();

    // Starvation guard, STARVE_MAX=2: expect D, D, I, D, D, I (bit = 1 for fetch)
    if_req = 1'b1; if_addr = 32'h08; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100;
    d_wdata = 32'h1; mem_read_data = 32'h55;
    ngr = 0; dbl = 0; seq = '0;
    for (int c = 0; c < 30 && ngr < 6; c++) begin
      tick();
      if (a_if_gnt && a_d_gnt) dbl++;
      if (a_if_gnt || a_d_gnt) begin
        seq[ngr] = a_if_gnt;
        ngr++;
      end
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    check("starve_count", 32'(ngr), 32'd6);
    check("starve_order", 32'(seq), 32'b100100);
    check("starve_double", 32'(dbl), 32'd0);
    for (int c = 0; c < 10 && a_busy; c++) tick();
    check("starve_idle", 32'(a_busy), 32'd0);

    // MEM_LAT=3 load on dut_b
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_read_data = 32'hAAAA0001;
    tick();                                    // T1
    check("l3_t1_gnt", 32'(b_d_gnt), 32'd1);
    check("l3_t1_addr", b_mem_addr, 32'h200);
    d_req = 1'b0; mem_read_data = 32'hBBBB0002;
    tick();                                    // T2
    check("l3_t2_addr", b_mem_addr, 32'h200);
    tick();                                    // T3
    check("l3_t3_addr", b_mem_addr, 32'h200);
    check("l3_t3_rvalid", 32'(b_d_rvalid), 32'd0);
    mem_read_data = 32'hCCCC0003;
    tick();                                    // T4, last RWAIT
    check("l3_t4_addr", b_mem_addr, 32'h200);
    check("l3_t4_rvalid", 32'(b_d_rvalid), 32'd0);
    tick();                                    // T5 RESP
    check("l3_t5_rvalid", 32'(b_d_rvalid), 32'd1);
    check("l3_t5_rdata", b_d_rdata, 32'hCCCC0003);
    tick();

    // Reset during RWAIT on dut_b
    if_req = 1'b1; if_addr = 32'h300;
    tick();                                    // T1
    check("rr_t1_gnt", 32'(b_if_gnt), 32'd1);
    if_req = 1'b0;
    tick();                                    // T2 RWAIT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_outs", {28'd0, b_busy, b_if_gnt, b_if_rvalid, b_mem_write_en}, 32'd0);
    check("rr_addr", b_mem_addr, 32'd0);
    check("rr_d_rdata", b_d_rdata, 32'd0);
    nrv = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (b_if_rvalid || b_d_rvalid) nrv++;
    end
    check("rr_no_rvalid", 32'(nrv), 32'd0);
    if_req = 1'b1; if_addr = 32'h304; mem_read_data = 32'hCAFEF00D;
    tick();
    lat = 1;
    check("rr_fresh_gnt", 32'(b_if_gnt), 32'd1);
    if_req = 1'b0;
    while (!b_if_rvalid && lat < 12) begin
      tick();
      lat++;
    end
    check("rr_fresh_lat", 32'(lat), 32'd5);
    check("rr_fresh_rdata", b_if_rdata, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
